// File: rtl/rr_merge.sv
// rr_merge: round-robin gather arbiter.
//
// Merges n valid/ready result streams (one per core) into a single registered
// output stream. Each output word carries the index of the core it came from.
// The output register adds exactly one cycle of latency and sustains one word
// per cycle while s_ready stays high.
//
// Parameters:
//   width  data bits per word
//   n      number of input streams (n >= 2)
//   idw    width of the source index
//
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous, active-high reset
//   m_data   input words, stream i at bits [i*width +: width]
//   m_valid  per-stream valid
//   m_ready  per-stream ready (combinational, at most one bit high)
//   s_data   merged output word (registered)
//   s_valid  merged output valid (registered)
//   s_id     source stream index of s_data (registered)
//   s_ready  downstream ready
module rr_merge #(
  parameter int width = 8,
  parameter int n     = 2,
  parameter int idw   = $clog2(n)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [n*width-1:0] m_data,
  input  logic [n-1:0]       m_valid,
  output logic [n-1:0]       m_ready,
  output logic [width-1:0]   s_data,
  output logic               s_valid,
  output logic [idw-1:0]     s_id,
  input  logic               s_ready
);

  // Index of the most recently granted stream; the search starts just after it.
  logic [idw-1:0]   ptr;
  logic             grant_valid;
  logic [idw-1:0]   grant_idx;
  logic [width-1:0] grant_data;
  logic             le;

  // The output register can take a new word when it is empty or is being
  // consumed this cycle, which allows back-to-back transfers.
  assign le = !s_valid || s_ready;

  // Rotating-priority search split into two ordered scans: first the streams
  // above ptr, then the streams from 0 up to and including ptr. This gives the
  // ptr+1, ptr+2, ... modulo n order without a runtime modulo.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    for (int i = 0; i < n; i++) begin
      if (!grant_valid && m_valid[i] && (idw'(i) > ptr)) begin
        grant_valid = 1'b1;
        grant_idx   = idw'(i);
        grant_data  = m_data[i*width +: width];
      end
    end
    for (int i = 0; i < n; i++) begin
      if (!grant_valid && m_valid[i] && (idw'(i) <= ptr)) begin
        grant_valid = 1'b1;
        grant_idx   = idw'(i);
        grant_data  = m_data[i*width +: width];
      end
    end
  end

  // Only the winning stream sees ready, and only when the output register
  // can accept; during a stall every ready bit stays low.
  always_comb begin
    m_ready = '0;
    if (grant_valid) begin
      m_ready[grant_idx] = le;
    end
  end

  // Output register and priority pointer. The pointer moves only on an actual
  // input transfer, so stalls and idle cycles never disturb fairness.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_valid <= 1'b0;
      s_data  <= '0;
      s_id    <= '0;
      ptr     <= idw'(n - 1);
    end else if (le) begin
      if (grant_valid) begin
        s_valid <= 1'b1;
        s_data  <= grant_data;
        s_id    <= grant_idx;
        ptr     <= grant_idx;
      end else begin
        s_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_merge.sv
// tb_rr_merge: directed bench for rr_merge with a two-stream and a
// four-stream instance sharing one clock and reset.
module tb_rr_merge;

  logic clock = 1'b0;
  logic reset = 1'b1;

  // Two-stream instance
  logic [15:0] data2;
  logic [1:0]  valid2;
  logic [1:0]  ready2;
  logic [7:0]  sdata2;
  logic        svalid2;
  logic        sid2;
  logic        sready2;

  // Four-stream instance
  logic [31:0] data4;
  logic [3:0]  valid4;
  logic [3:0]  ready4;
  logic [7:0]  sdata4;
  logic        svalid4;
  logic [1:0]  sid4;
  logic        sready4;

  rr_merge #(.width(8), .n(2)) dut2 (
    .clock  (clock),
    .reset  (reset),
    .m_data (data2),
    .m_valid(valid2),
    .m_ready(ready2),
    .s_data (sdata2),
    .s_valid(svalid2),
    .s_id   (sid2),
    .s_ready(sready2)
  );

  rr_merge #(.width(8), .n(4)) dut4 (
    .clock  (clock),
    .reset  (reset),
    .m_data (data4),
    .m_valid(valid4),
    .m_ready(ready4),
    .s_data (sdata4),
    .s_valid(svalid4),
    .s_id   (sid4),
    .s_ready(sready4)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Upstream source model: next word each stream will offer
  logic [7:0] nxt0;
  logic [7:0] nxt1;

  // Values seen just before the active edge of the latest step
  logic [1:0] rdy_seen;
  logic       pre_sv;
  logic       pre_sr;
  logic       pre_sid;
  logic [7:0] pre_sd;

  // Scoreboard: words accepted from each stream, awaiting output
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int words_in  = 0;
  int words_out = 0;

  logic [7:0] cont_exp [8];
  int         w_id [4];
  int         outcnt;

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock step on the two-stream instance: drive inputs at the falling
  // edge, sample combinational ready, then update the source model and the
  // scoreboard after the rising edge.
  task applyStimulus(input logic [1:0] v, input logic sr);
    @(negedge clock);
    valid2  = v;
    data2   = {nxt1, nxt0};
    sready2 = sr;
    #1;
    rdy_seen = ready2;
    pre_sv   = svalid2;
    pre_sr   = sr;
    pre_sd   = sdata2;
    pre_sid  = sid2;
    checkOutput("ready_onehot", 32'($countones(ready2) <= 1), 1);
    checkOutput("ready_only_valid", 32'(rdy_seen & ~v), 0);
    if (pre_sv && !pre_sr) begin
      checkOutput("stall_ready_low", 32'(rdy_seen), 0);
    end
    @(posedge clock);
    #1;
    if (pre_sv && !pre_sr) begin
      checkOutput("stall_valid", 32'(svalid2), 1);
      checkOutput("stall_data", 32'(sdata2), 32'(pre_sd));
      checkOutput("stall_id", 32'(sid2), 32'(pre_sid));
    end
    if (pre_sv && pre_sr) begin
      words_out++;
      if (pre_sid == 1'b0) begin
        checkOutput("sb_nonempty0", 32'(q0.size() > 0), 1);
        if (q0.size() > 0) checkOutput("sb_data0", 32'(pre_sd), 32'(q0.pop_front()));
      end else begin
        checkOutput("sb_nonempty1", 32'(q1.size() > 0), 1);
        if (q1.size() > 0) checkOutput("sb_data1", 32'(pre_sd), 32'(q1.pop_front()));
      end
    end
    if (rdy_seen[0]) begin
      q0.push_back(nxt0);
      nxt0++;
      words_in++;
    end
    if (rdy_seen[1]) begin
      q1.push_back(nxt1);
      nxt1++;
      words_in++;
    end
  endtask

  initial begin
    cont_exp = '{8'h00, 8'h80, 8'h01, 8'h81, 8'h02, 8'h82, 8'h03, 8'h83};
    w_id     = '{1, 3, 1, 3};
    data2 = '0; valid2 = '0; sready2 = 1'b1;
    data4 = '0; valid4 = '0; sready4 = 1'b1;
    nxt0 = 8'h00; nxt1 = 8'h80;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_valid", 32'(svalid2), 0);
    checkOutput("rst_data", 32'(sdata2), 0);
    checkOutput("rst_id", 32'(sid2), 0);
    checkOutput("rst_valid4", 32'(svalid4), 0);

    // Load one word, then reset asynchronously while it is held
    @(negedge clock);
    reset  = 1'b0;
    valid2 = 2'b11;
    data2  = {8'hA1, 8'hA0};
    #1;
    checkOutput("first_ready", 32'(ready2), 32'b01);
    @(posedge clock);
    #1;
    checkOutput("held_valid", 32'(svalid2), 1);
    checkOutput("held_data", 32'(sdata2), 32'hA0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(svalid2), 0);
    checkOutput("async_rst_data", 32'(sdata2), 0);
    checkOutput("async_rst_id", 32'(sid2), 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(ready2), 32'b01);
    @(posedge clock);
    #1;
    checkOutput("post_rst_id", 32'(sid2), 0);
    checkOutput("post_rst_data", 32'(sdata2), 32'hA0);
    @(negedge clock);
    valid2 = 2'b00;
    @(posedge clock);
    #1;
    checkOutput("drain_valid", 32'(svalid2), 0);
    checkOutput("drain_data_hold", 32'(sdata2), 32'hA0);

    // Single stream: only stream 1 offers 0x10..0x12
    nxt1 = 8'h10;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b10, 1'b1);
      if (k == 0) checkOutput("single_ready", 32'(rdy_seen), 32'b10);
      checkOutput("single_valid", 32'(svalid2), 1);
      checkOutput("single_data", 32'(sdata2), 32'h10 + k);
      checkOutput("single_id", 32'(sid2), 1);
    end
    applyStimulus(2'b00, 1'b1);
    checkOutput("single_end", 32'(svalid2), 0);

    // Contention: both streams valid until their four words are sent
    nxt0 = 8'h00; nxt1 = 8'h80;
    for (int k = 0; k < 8; k++) begin
      applyStimulus({nxt1 < 8'h84, nxt0 < 8'h04}, 1'b1);
      checkOutput("cont_valid", 32'(svalid2), 1);
      checkOutput("cont_data", 32'(sdata2), 32'(cont_exp[k]));
      checkOutput("cont_id", 32'(sid2), k % 2);
    end
    applyStimulus(2'b00, 1'b1);
    checkOutput("cont_end", 32'(svalid2), 0);

    // Backpressure: same traffic with s_ready low every third cycle
    nxt0 = 8'h00; nxt1 = 8'h80;
    outcnt = 0;
    for (int c = 0; c < 40 && outcnt < 8; c++) begin
      applyStimulus({nxt1 < 8'h84, nxt0 < 8'h04}, (c % 3) != 0);
      if (pre_sv && pre_sr) begin
        checkOutput("bp_data", 32'(pre_sd), 32'(cont_exp[outcnt]));
        checkOutput("bp_id", 32'(pre_sid), outcnt % 2);
        outcnt++;
      end
    end
    checkOutput("bp_count", outcnt, 8);
    checkOutput("bp_drained", 32'(svalid2), 0);

    // Irregular valid and ready pattern checked by the scoreboard
    for (int c = 0; c < 100; c++) begin
      applyStimulus({(c % 4) != 0, (c % 5) != 0}, (c % 3) != 0);
    end
    for (int c = 0; c < 6; c++) begin
      applyStimulus(2'b00, 1'b1);
    end
    checkOutput("irr_q0_empty", q0.size(), 0);
    checkOutput("irr_q1_empty", q1.size(), 0);
    checkOutput("irr_in_eq_out", words_in, words_out);
    checkOutput("irr_enough_traffic", 32'(words_in >= 50), 1);
    checkOutput("irr_end_valid", 32'(svalid2), 0);

    // Four streams, only 1 and 3 valid: grants alternate and wrap past 3
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      valid4 = 4'b1010;
      data4  = {8'h33, 8'h22, 8'h11, 8'h00};
      #1;
      checkOutput("wrap_ready", 32'(ready4), 32'(4'b0001 << w_id[k]));
      @(posedge clock);
      #1;
      checkOutput("wrap_id", 32'(sid4), w_id[k]);
      checkOutput("wrap_data", 32'(sdata4), 32'h11 * w_id[k]);
    end
    @(negedge clock);
    valid4 = 4'b1011;
    #1;
    checkOutput("wrap_to0_ready", 32'(ready4), 32'b0001);
    @(posedge clock);
    #1;
    checkOutput("wrap_to0_id", 32'(sid4), 0);
    checkOutput("wrap_to0_data", 32'(sdata4), 32'h00);
    @(negedge clock);
    #1;
    checkOutput("wrap_next_ready", 32'(ready4), 32'b0010);
    @(posedge clock);
    #1;
    checkOutput("wrap_next_id", 32'(sid4), 1);
    @(negedge clock);
    valid4 = 4'b0000;
    @(posedge clock);
    #1;
    checkOutput("wrap_end", 32'(svalid4), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_merge.md
Name: rr_merge

Overview:
- Round-robin arbiter that merges N valid/ready result streams, one per core, into one output stream.
- Sits downstream of the per-core pipelines and is the gather-side counterpart of the broadcast fan-out.
- Shares the single output channel fairly between the cores.
- Tags each output word with its source core index.
- Output is registered, giving exactly 1 cycle of latency.

Parameters:
- width, 8, data bits per word.
- n, 2, number of input streams; n >= 2.
- idw, $clog2(n), bit width of the source index.

Ports:
- clock  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset; asynchronous, active-high.
- m_data  input  n*width  input data; stream i occupies bits [i*width +: width].
- m_valid  input  n  per-stream valid.
- m_ready  output  n  per-stream ready; combinational; at most one bit high per cycle.
- s_data  output  width  merged data; registered.
- s_valid  output  1  merged valid; registered.
- s_id  output  idw  index of the source stream of s_data; registered.
- s_ready  input  1  downstream ready.

Behaviour:
- Reset values: s_valid=0, s_data=0, s_id=0.
- The priority pointer ptr resets to n-1, so stream 0 has highest priority on the first grant.
- Reset asserted mid-transfer discards the held word. Words offered but not yet accepted are unaffected; their senders keep holding them.
- Output register state "load-enable": le = !s_valid || s_ready.
- Grant selection:
  - Combinational.
  - g is the first i with m_valid[i]=1, scanning ptr+1, ptr+2, ... modulo n.
  - No grant when m_valid==0.
- Ready generation:
  - m_ready[g] = le, for the granted stream only; all other m_ready bits are 0.
  - m_ready may depend on m_valid.
  - m_ready never depends on m_data.
- Load (rising edge with le && grant):
  - s_data <= m_data[g]
  - s_id <= g
  - s_valid <= 1
  - ptr <= g
- Drain (rising edge with le && no grant): s_valid <= 0; s_data and s_id hold their values.
- Stall (s_valid && !s_ready):
  - s_data, s_id and s_valid hold stable.
  - All m_ready bits are 0.
  - ptr holds.
- Throughput: one word per cycle when s_ready is held high. A simultaneous consume and load in the same cycle is required; no bubble is allowed.
- Fairness:
  - With k streams continuously valid, each is granted once every k accepted words.
  - No stream waits more than n-1 grants once its valid is high.
- ptr advances only on an actual transfer. Pointer wrap n-1 -> 0 is modular.
- Input protocol assumed of upstream: once m_valid[i] is high, it and m_data[i] stay stable until the m_ready[i] handshake. The arbiter does not depend on this for correctness, but it is required for fairness.
- Latency: an input handshake at edge t gives s_valid=1 with the data after edge t.
- Word counts: out transfers = sum of in transfers.
- No loss or duplication across any stall pattern.
- Order within a stream is preserved.

Test Plan:
- Reset:
  - Stimulus: assert reset asynchronously between edges while s_valid=1.
  - Response: s_valid=0, s_data=0, s_id=0 immediately, with no clock edge needed.
  - After release, with both inputs valid, the first output has s_id=0.
- Single stream:
  - Stimulus: n=2; only m_valid[1] high with data 0x10,0x11,0x12; s_ready=1.
  - Response: outputs 0x10,0x11,0x12, all with s_id=1, on consecutive cycles, 1-cycle latency, no bubbles.
- Contention:
  - Stimulus: both streams continuously valid; stream0 sends 0x00..0x03, stream1 sends 0x80..0x83; s_ready=1.
  - Response, exact sequence: 00,80,01,81,02,82,03,83.
  - s_id alternates 0,1,0,1,...
- Backpressure:
  - Stimulus: same as contention, with s_ready low whenever cycle%3==0.
  - Response:
    - Words held stable while stalled.
    - m_ready all 0 during stalls.
    - Same output order as contention.
    - 8 words out total.
- Irregular pattern:
  - Stimulus: m_valid[0] low when cnt%5==0; m_valid[1] low when cnt%4==0; s_ready low when cnt%3==0; 100 cycles; incrementing data per stream.
  - Response, via scoreboard:
    - Every accepted word appears exactly once.
    - Per-stream order is preserved.
    - At most one m_ready bit high in any cycle.
- Wrap, n=4:
  - Stimulus: streams 1 and 3 valid only.
  - Response: grants alternate 1,3,1,3; ptr wraps correctly from 3 back to 1.
  - Grants to stream 0 or 2 occur only when those streams are valid.
